gates_result_checker: RTL

GATES_RESULT_CHECKER -- requirements
Module: gates_result_checker

---
 rtl/gates_pkg.sv | 19 +
 rtl/gates_golden_model.sv | 22 ++
 rtl/gates_result_checker.sv | 108 ++++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// Shared constants for the gate result checker: y bit positions, result width
// and the checker FSM state encoding.
package gates_pkg;

    localparam int RES_W = 7;

    localparam int IDX_AND  = 6;
    localparam int IDX_OR   = 5;
    localparam int IDX_NOTB = 4;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gates_golden_model.sv
// Purely combinational reference: the seven gate results a correct unit under
// test should produce for operands a and b.
module gates_golden_model
    import gates_pkg::*;
(
    input  logic             a,
    input  logic             b,
    output logic [RES_W-1:0] exp
);

    always_comb begin
        exp           = '0;
        exp[IDX_AND]  = a & b;
        exp[IDX_OR]   = a | b;
        exp[IDX_NOTB] = ~b;
        exp[IDX_NAND] = ~(a & b);
        exp[IDX_NOR]  = ~(a | b);
        exp[IDX_XOR]  = a ^ b;
        exp[IDX_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gates_result_checker.sv
// Run-based checker: accepts VEC_COUNT vectors per run, counts mismatches
// against the golden model and captures the first failing vector.
module gates_result_checker
    import gates_pkg::*;
#(
    parameter int VEC_COUNT = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic [RES_W-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [RES_W-1:0] first_err_mask
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [RES_W-1:0] first_mask_q, first_mask_d;

    logic [RES_W-1:0] expVec;
    logic [RES_W-1:0] mask;
    logic [CNT_W-1:0] vecNext;
    logic             transfer;

    gates_golden_model u_golden (
        .a   (a),
        .b   (b),
        .exp (expVec)
    );

    assign mask     = y ^ expVec;
    assign transfer = in_valid && in_ready;
    assign vecNext  = vec_cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        vec_cnt_d    = vec_cnt_q;
        err_cnt_d    = err_cnt_q;
        first_idx_d  = first_idx_q;
        first_mask_d = first_mask_q;
        case (state_q)
            ST_RUN: begin
                if (transfer) begin
                    vec_cnt_d = vecNext;
                    if (mask != '0) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                        // err_cnt_q is still zero only for the run's first mismatch
                        if (err_cnt_q == '0) begin
                            first_idx_d  = vec_cnt_q;
                            first_mask_d = mask;
                        end
                    end
                    if (vecNext == CNT_W'(VEC_COUNT)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    vec_cnt_d    = '0;
                    err_cnt_d    = '0;
                    first_idx_d  = '0;
                    first_mask_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_mask_q <= '0;
        end else begin
            state_q      <= state_d;
            vec_cnt_q    <= vec_cnt_d;
            err_cnt_q    <= err_cnt_d;
            first_idx_q  <= first_idx_d;
            first_mask_q <= first_mask_d;
        end
    end

    assign in_ready       = (state_q == ST_RUN);
    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_cnt_q == '0);
    assign vec_cnt        = vec_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_mask = first_mask_q;

endmodule
